lif_neuron: RTL

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_pkg.sv | 24 ++
 rtl/lif_synapse.sv | 63 ++++++
 rtl/lif_neuron.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and default configuration for the leaky integrate-and-fire neuron.
// Optional STDP learning is enabled by defining LIF_STDP_EN.
package lif_pkg;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } lif_state_t;

  localparam int LIF_N_IN_DEF        = 4;
  localparam int LIF_W_WT_DEF        = 8;
  localparam int LIF_W_POT_DEF       = 10;
  localparam int LIF_THRESHOLD_DEF   = 256;
  localparam int LIF_LEAK_SHIFT_DEF  = 3;
  localparam int LIF_REFRACT_CYC_DEF = 4;
  localparam int LIF_W_INIT_DEF      = 32;
  localparam int LIF_TRACE_LEN_DEF   = 3;

  // Bits needed to encode 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_synapse.sv
// One synapse: stored weight, write port and, when LIF_STDP_EN is defined,
// a pre-synaptic trace with saturating STDP potentiation/depression.
module lif_synapse
  import lif_pkg::*;
#(
  parameter int W_WT      = LIF_W_WT_DEF,
  parameter int W_INIT    = LIF_W_INIT_DEF,
  parameter int TRACE_LEN = LIF_TRACE_LEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spike_in,
  input  logic            stdp_upd,
  input  logic            wr_en,
  input  logic [W_WT-1:0] wr_data,
  output logic [W_WT-1:0] weight
);

`ifdef LIF_STDP_EN
  localparam int W_TR = clog2_min1(TRACE_LEN + 1);

  logic [W_TR-1:0] trace;

  // Trace reloads on every pre-synaptic spike and otherwise decays to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace <= '0;
    end else if (spike_in) begin
      trace <= W_TR'(TRACE_LEN);
    end else if (trace != '0) begin
      trace <= trace - 1'b1;
    end
  end

  // Weight storage: reset, then write port, then STDP (old trace value is used).
  always_ff @(posedge clk) begin
    if (reset) begin
      weight <= W_WT'(W_INIT);
    end else if (wr_en) begin
      weight <= wr_data;
    end else if (stdp_upd) begin
      if ((trace != '0) || spike_in) begin
        weight <= (&weight) ? weight : weight + 1'b1;
      end else begin
        weight <= (|weight) ? weight - 1'b1 : weight;
      end
    end
  end
`else
  logic stdp_unused;
  assign stdp_unused = stdp_upd ^ spike_in;

  // Weight storage: reset or write port only.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight <= W_WT'(W_INIT);
    end else if (wr_en) begin
      weight <= wr_data;
    end
  end
`endif

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with N_IN weighted synapses, saturating
// membrane potential, refractory period and optional STDP (LIF_STDP_EN).
module lif_neuron
  import lif_pkg::*;
#(
  parameter int N_IN        = LIF_N_IN_DEF,
  parameter int W_WT        = LIF_W_WT_DEF,
  parameter int W_POT       = LIF_W_POT_DEF,
  parameter int THRESHOLD   = LIF_THRESHOLD_DEF,
  parameter int LEAK_SHIFT  = LIF_LEAK_SHIFT_DEF,
  parameter int REFRACT_CYC = LIF_REFRACT_CYC_DEF,
  parameter int W_INIT      = LIF_W_INIT_DEF,
  parameter int TRACE_LEN   = LIF_TRACE_LEN_DEF,
  localparam int W_IDX      = clog2_min1(N_IN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_spikes,
  input  logic             learn,
  input  logic             wt_wr_en,
  input  logic [W_IDX-1:0] wt_wr_idx,
  input  logic [W_WT-1:0]  wt_wr_data,
  output logic             spike_out,
  output logic [W_POT-1:0] potential,
  output logic             refractory
);

  localparam int W_SUM  = W_WT + $clog2(N_IN) + 1;
  localparam int W_NEXT = ((W_POT > W_SUM) ? W_POT : W_SUM) + 1;
  localparam int W_CNT  = clog2_min1(REFRACT_CYC + 1);

  if ((N_IN < 1) || (N_IN > 16)) begin : g_bad_n_in
    $error("lif_neuron: N_IN must be in 1..16");
  end
  if (THRESHOLD > (2 ** W_POT) - 1) begin : g_bad_threshold
    $error("lif_neuron: THRESHOLD exceeds 2^W_POT-1");
  end

  lif_state_t       state;
  logic [W_CNT-1:0] cnt;
  logic [W_WT-1:0]  weight [N_IN];
  logic [W_SUM-1:0] sum;
  logic [W_POT-1:0] leaked;
  logic [W_NEXT-1:0] next_wide;
  logic [W_POT-1:0] next_pot;
  logic             fire;
  logic             stdp_upd;

  for (genvar g = 0; g < N_IN; g++) begin : g_syn
    lif_synapse #(
      .W_WT      (W_WT),
      .W_INIT    (W_INIT),
      .TRACE_LEN (TRACE_LEN)
    ) u_syn (
      .clk      (clk),
      .reset    (reset),
      .spike_in (in_spikes[g]),
      .stdp_upd (stdp_upd),
      .wr_en    (wt_wr_en && (wt_wr_idx == W_IDX'(g))),
      .wr_data  (wt_wr_data),
      .weight   (weight[g])
    );
  end

  // Synaptic sum, leak and saturating next potential; fire decision.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (in_spikes[i]) sum = sum + W_SUM'(weight[i]);
    end
    leaked    = potential - (potential >> LEAK_SHIFT);
    next_wide = W_NEXT'(leaked) + W_NEXT'(sum);
    if (next_wide > W_NEXT'({W_POT{1'b1}})) begin
      next_pot = '1;
    end else begin
      next_pot = next_wide[W_POT-1:0];
    end
    fire     = (state == INTEGRATE) && (next_pot >= W_POT'(THRESHOLD));
    stdp_upd = fire && learn;
  end

  // Integrate/refractory state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INTEGRATE;
      cnt        <= '0;
      potential  <= '0;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
    end else begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            spike_out <= 1'b1;
            potential <= '0;
            if (REFRACT_CYC != 0) begin
              state      <= REFRACT;
              cnt        <= W_CNT'(REFRACT_CYC);
              refractory <= 1'b1;
            end
          end else begin
            spike_out <= 1'b0;
            potential <= next_pot;
          end
        end
        REFRACT: begin
          spike_out <= 1'b0;
          potential <= '0;
          if (cnt <= W_CNT'(1)) begin
            state      <= INTEGRATE;
            cnt        <= '0;
            refractory <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= INTEGRATE;
          refractory <= 1'b0;
        end
      endcase
    end
  end

endmodule
